// File: rtl/iir_block_engine_if.sv
// Wishbone classic slave bundle for the IIR block engine.
// The bus side is 32-bit word access; byte selects travel along but are not used.
interface iir_block_engine_if;
  logic [31:0] wb_adr;
  logic [31:0] wb_dat_w;
  logic [3:0]  wb_sel;
  logic        wb_we;
  logic        wb_cyc;
  logic        wb_stb;
  logic [31:0] wb_dat_r;
  logic        wb_ack;
  logic        wb_err;

  modport master (
    output wb_adr, wb_dat_w, wb_sel, wb_we, wb_cyc, wb_stb,
    input  wb_dat_r, wb_ack, wb_err
  );

  modport slave (
    input  wb_adr, wb_dat_w, wb_sel, wb_we, wb_cyc, wb_stb,
    output wb_dat_r, wb_ack, wb_err
  );
endinterface

// File: rtl/iir_block_engine.sv
// Block sequencer: streams a loaded sample buffer through a fixed-latency filter
// core and captures the core's outputs into a readback buffer.
//
// state   | meaning
// S_IDLE  | waiting for start
// S_FEED  | one xbuf sample per clock to the core
// S_DRAIN | feed finished, waiting for the last delayed capture
// S_DONE  | one-cycle completion, sets sticky done
module iir_block_engine #(
  parameter int DW       = 32,
  parameter int DEPTH    = 32,
  parameter int FILT_LAT = 9
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_ni,
  iir_block_engine_if.slave wb,
  output logic              int_o,
  output logic [DW-1:0]     flt_in_o,
  output logic              flt_in_vld_o,
  input  logic [DW-1:0]     flt_out_i
);
  localparam int AW_B = $clog2(DEPTH);
  localparam int LW   = AW_B + 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_FEED, S_DRAIN, S_DONE} state_t;

  state_t r_state, w_state_nxt;

  logic                r_ack;
  logic [31:0]         r_dat;
  logic                r_irq_en;
  logic                r_done;
  logic                r_err;
  logic                r_start;
  logic [LW-1:0]       r_len;
  logic [LW-1:0]       r_k;
  logic [LW-1:0]       r_j;
  logic [AW_B-1:0]     r_waddr;
  logic [AW_B-1:0]     r_raddr;
  logic [FILT_LAT-1:0] r_vld_sr;
  logic [DW-1:0]       r_xbuf [DEPTH];
  logic [DW-1:0]       r_ybuf [DEPTH];

  logic          w_acc, w_wr, w_rd, w_busy, w_cap, w_last_cap;
  logic          w_done_set, w_start_ok, w_wr_blocked;
  logic          w_done_clr, w_err_clr;
  logic [3:0]    w_reg;
  logic [31:0]   w_rdata;
  logic [LW-1:0] w_len_wr;
  logic          w_unused;

  assign w_acc   = wb.wb_cyc & wb.wb_stb & ~r_ack;
  assign w_wr    = w_acc & wb.wb_we;
  assign w_rd    = w_acc & ~wb.wb_we;
  assign w_reg   = wb.wb_adr[5:2];
  assign w_busy  = (r_state == S_FEED) || (r_state == S_DRAIN);
  assign w_cap   = r_vld_sr[FILT_LAT-1] & w_busy;
  assign w_last_cap = w_cap && (r_j == r_len - LW'(1));

  assign w_start_ok   = w_wr && (w_reg == 4'd0) && wb.wb_dat_w[0] && !w_busy;
  assign w_wr_blocked = w_wr && w_busy &&
                        (((w_reg == 4'd0) && wb.wb_dat_w[0]) ||
                         (w_reg == 4'd2) || (w_reg == 4'd3) ||
                         (w_reg == 4'd4) || (w_reg == 4'd5));
  assign w_done_clr = (w_wr && (w_reg == 4'd1) && wb.wb_dat_w[1]) || w_start_ok;
  assign w_err_clr  = w_wr && (w_reg == 4'd1) && wb.wb_dat_w[2];
  assign w_done_set = (w_state_nxt == S_DONE) && (r_state != S_DONE);
  assign w_len_wr   = (wb.wb_dat_w > 32'(DEPTH)) ? DEPTH_L : wb.wb_dat_w[LW-1:0];

  assign wb.wb_ack   = r_ack;
  assign wb.wb_dat_r = r_dat;
  assign wb.wb_err   = 1'b0;
  assign int_o       = r_done & r_irq_en;
  assign w_unused    = &{1'b0, wb.wb_sel, wb.wb_adr[31:6], wb.wb_adr[1:0]};

  always_comb begin
    w_state_nxt  = r_state;
    flt_in_vld_o = 1'b0;
    flt_in_o     = '0;
    case (r_state)
      S_IDLE:  if (r_start) w_state_nxt = (r_len == '0) ? S_DONE : S_FEED;
      S_FEED: begin
        flt_in_vld_o = 1'b1;
        flt_in_o     = r_xbuf[r_k[AW_B-1:0]];
        if (r_k == r_len - LW'(1)) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: if (w_last_cap) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_rdata = '0;
    case (w_reg)
      4'd0: w_rdata[1]        = r_irq_en;
      4'd1: w_rdata[2:0]      = {r_err, r_done, w_busy};
      4'd2: w_rdata[LW-1:0]   = r_len;
      4'd3: w_rdata[AW_B-1:0] = r_waddr;
      4'd5: w_rdata[AW_B-1:0] = r_raddr;
      4'd6: w_rdata[DW-1:0]   = r_ybuf[r_raddr];
      default: w_rdata = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_state  <= S_IDLE;
      r_k      <= '0;
      r_j      <= '0;
      r_vld_sr <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_vld_sr[0] <= flt_in_vld_o;
      for (int i = 1; i < FILT_LAT; i++) r_vld_sr[i] <= r_vld_sr[i-1];
      if (r_state == S_IDLE) begin
        r_k <= '0;
        r_j <= '0;
      end else begin
        if (flt_in_vld_o) r_k <= r_k + LW'(1);
        if (w_cap)        r_j <= r_j + LW'(1);
      end
    end
  end

  // Read data is loaded on every access; register side effects act on the same edge.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_ack    <= 1'b0;
      r_dat    <= '0;
      r_irq_en <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_start  <= 1'b0;
      r_len    <= '0;
      r_waddr  <= '0;
      r_raddr  <= '0;
    end else begin
      r_ack <= w_acc;
      if (w_acc) r_dat <= w_rdata;
      if (w_wr) begin
        case (w_reg)
          4'd0: r_irq_en <= wb.wb_dat_w[1];
          4'd2: if (!w_busy) r_len <= w_len_wr;
          4'd3: if (!w_busy) r_waddr <= wb.wb_dat_w[AW_B-1:0];
          4'd4: if (!w_busy) r_waddr <= r_waddr + AW_B'(1);
          4'd5: if (!w_busy) r_raddr <= wb.wb_dat_w[AW_B-1:0];
          default: ;
        endcase
      end
      if (w_rd && (w_reg == 4'd6)) r_raddr <= r_raddr + AW_B'(1);
      if (w_start_ok)              r_start <= 1'b1;
      else if (r_state == S_IDLE)  r_start <= 1'b0;
      if (w_done_set)      r_done <= 1'b1;
      else if (w_done_clr) r_done <= 1'b0;
      if (w_wr_blocked)    r_err <= 1'b1;
      else if (w_err_clr)  r_err <= 1'b0;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (w_wr && (w_reg == 4'd4) && !w_busy) r_xbuf[r_waddr] <= wb.wb_dat_w[DW-1:0];
  end

  always_ff @(posedge wb_clk_i) begin
    if (w_cap) r_ybuf[r_j[AW_B-1:0]] <= flt_out_i;
  end
endmodule

// File: tb/tb_iir_block_engine.sv
// Randomised bench for iir_block_engine with a stub filter core (y = 3x+1, delayed FILT_LAT)
// and a register/buffer-level reference model.
`timescale 1ns/1ps
module tb_iir_block_engine;
  localparam int DW    = 16;
  localparam int DEPTH = 32;
  localparam int LAT   = 9;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          irq;
  logic          flt_vld;
  logic [DW-1:0] flt_in;
  logic [DW-1:0] flt_out;

  always #5 clk = ~clk;

  iir_block_engine_if bus ();

  iir_block_engine #(.DW(DW), .DEPTH(DEPTH), .FILT_LAT(LAT)) dut (
    .wb_clk_i    (clk),
    .wb_rst_ni   (rst_n),
    .wb          (bus.slave),
    .int_o       (irq),
    .flt_in_o    (flt_in),
    .flt_in_vld_o(flt_vld),
    .flt_out_i   (flt_out)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] fm(input logic [DW-1:0] x);
    return DW'(32'(x) * 32'd3 + 32'd1);
  endfunction

  // stub filter core
  logic [DW-1:0] pipe [LAT];
  always @(posedge clk) begin
    pipe[0] <= fm(flt_in);
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign flt_out = pipe[LAT-1];

  // reference model
  logic [DW-1:0] xm [DEPTH];
  logic [DW-1:0] ym [DEPTH];
  int m_len, m_waddr, m_raddr, m_run_n;
  bit m_irq, m_done, m_err, m_busy;

  int cyc_cnt    = 0;
  int feed_idx   = 0;
  int vld_cnt    = 0;
  int feed_start = -1;
  int int_rise   = -1;
  logic vld_q = 1'b0;
  logic irq_q = 1'b0;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  always @(negedge clk) begin
    if (rst_n && flt_vld) begin
      if (!vld_q) feed_start = cyc_cnt;
      chk("feed_data", 32'(flt_in), 32'(xm[feed_idx % DEPTH]));
      feed_idx++;
      vld_cnt++;
    end
    if (irq && !irq_q) int_rise = cyc_cnt;
    vld_q = flt_vld;
    irq_q = irq;
  end

  task automatic reset_model();
    m_len = 0; m_waddr = 0; m_raddr = 0; m_run_n = 0;
    m_irq = 0; m_done = 0; m_err = 0; m_busy = 0;
  endtask

  task automatic wb_xfer(input logic [3:0] reg_idx, input logic we, input logic [31:0] wdat,
                         output logic [31:0] rdat);
    bit got;
    got = 0;
    bus.wb_adr   = {26'h0, reg_idx, 2'b00};
    bus.wb_we    = we;
    bus.wb_dat_w = wdat;
    bus.wb_sel   = 4'hf;
    bus.wb_cyc   = 1'b1;
    bus.wb_stb   = 1'b1;
    for (int i = 0; i < 4 && !got; i++) begin
      @(posedge clk);
      #1;
      if (bus.wb_ack) got = 1;
    end
    rdat = bus.wb_dat_r;
    bus.wb_cyc = 1'b0;
    bus.wb_stb = 1'b0;
    bus.wb_we  = 1'b0;
    chk("ack", 32'(got), 32'd1);
  endtask

  task automatic reg_wr(input int idx, input logic [31:0] d);
    logic [31:0] rd;
    wb_xfer(4'(idx), 1'b1, d, rd);
    case (idx)
      0: begin
        m_irq = d[1];
        if (d[0]) begin
          if (m_busy) m_err = 1;
          else begin
            vld_cnt = 0; feed_idx = 0; feed_start = -1; int_rise = -1;
            m_run_n = m_len;
            m_done  = (m_len == 0);
            m_busy  = (m_len != 0);
          end
        end
      end
      1: begin
        if (d[1]) m_done = 0;
        if (d[2]) m_err = 0;
      end
      2: if (m_busy) m_err = 1; else m_len = (d > DEPTH) ? DEPTH : int'(d);
      3: if (m_busy) m_err = 1; else m_waddr = int'(d % DEPTH);
      4: if (m_busy) m_err = 1;
         else begin
           xm[m_waddr] = d[DW-1:0];
           m_waddr = (m_waddr + 1) % DEPTH;
         end
      5: if (m_busy) m_err = 1; else m_raddr = int'(d % DEPTH);
      default: ;
    endcase
  endtask

  task automatic reg_rd(input int idx, input string tag);
    logic [31:0] rd, exp;
    case (idx)
      0: exp = {30'd0, m_irq, 1'b0};
      1: exp = {29'd0, m_err, m_done, m_busy};
      2: exp = 32'(m_len);
      3: exp = 32'(m_waddr);
      5: exp = 32'(m_raddr);
      6: exp = 32'(ym[m_raddr]);
      default: exp = 32'd0;
    endcase
    wb_xfer(4'(idx), 1'b0, 32'h0, rd);
    if (idx == 6) m_raddr = (m_raddr + 1) % DEPTH;
    chk(tag, rd, exp);
  endtask

  task automatic wait_done(input string tag);
    logic [31:0] rd;
    bit seen;
    seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      wb_xfer(4'd1, 1'b0, 32'h0, rd);
      seen = rd[1];
    end
    chk({tag, "_done"}, 32'(seen), 32'd1);
    m_busy = 0;
    m_done = 1;
    for (int i = 0; i < m_run_n; i++) ym[i] = fm(xm[i]);
    chk({tag, "_vld_cnt"}, 32'(vld_cnt), 32'(m_run_n));
    if (m_irq) chk({tag, "_latency"}, 32'(int_rise - feed_start), 32'(m_run_n + LAT));
  endtask

  task automatic read_ybuf(input int n, input string tag);
    reg_wr(5, 32'd0);
    for (int i = 0; i < n; i++) reg_rd(6, tag);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [31:0] d;
    bus.wb_adr = '0; bus.wb_dat_w = '0; bus.wb_sel = '0;
    bus.wb_we = 1'b0; bus.wb_cyc = 1'b0; bus.wb_stb = 1'b0;
    reset_model();
    #23;
    chk("rst_vld", 32'(flt_vld), 32'd0);
    chk("rst_int", 32'(irq), 32'd0);
    chk("rst_ack", 32'(bus.wb_ack), 32'd0);
    chk("rst_dat", bus.wb_dat_r, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    foreach (d[i]) if (i < 16 && i != 6) reg_rd(i, "rst_reg");

    // length saturation and pointer wrap on the sample buffer
    reg_wr(2, 32'd100);
    reg_rd(2, "len_sat");
    reg_wr(3, 32'd31);
    reg_wr(4, $urandom);
    reg_wr(4, 32'h1234_ABCD);
    reg_rd(3, "waddr_wrap");
    reg_rd(4, "wdata_rd");
    for (int i = 1; i < 31; i++) reg_wr(4, 32'(i));

    // full-depth run, latency measured through the interrupt
    reg_wr(2, 32'd32);
    reg_wr(0, 32'd3);
    reg_rd(1, "full_busy");
    wait_done("full");
    reg_rd(1, "full_stat");
    read_ybuf(32, "full_y");
    reg_rd(5, "raddr_wrap");

    // interrupt follows done, W1C drops it
    reg_wr(2, 32'd4);
    reg_wr(0, 32'd3);
    wait_done("irq");
    chk("irq_set", 32'(irq), 32'd1);
    reg_wr(1, 32'd2);
    chk("irq_clr", 32'(irq), 32'd0);
    reg_rd(1, "irq_stat");
    read_ybuf(4, "irq_y");

    // writes while busy are ignored and flag err
    reg_wr(2, 32'd32);
    reg_wr(0, 32'd3);
    reg_wr(4, 32'hDEAD_BEEF);
    reg_wr(0, 32'd3);
    reg_wr(2, 32'd7);
    reg_wr(5, 32'd9);
    reg_wr(3, 32'd5);
    reg_rd(1, "busy_stat");
    reg_rd(2, "busy_len");
    wait_done("busy");
    reg_rd(3, "busy_waddr");
    read_ybuf(32, "busy_y");
    reg_rd(1, "busy_err");
    reg_wr(1, 32'd4);
    reg_rd(1, "err_clr");

    // empty run: start clears done, done returns next cycle without feeding
    reg_wr(2, 32'd0);
    reg_wr(0, 32'd3);
    chk("n0_start_clr", 32'(irq), 32'd0);
    @(posedge clk); #1;
    chk("n0_int", 32'(irq), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("n0_vld_cnt", 32'(vld_cnt), 32'd0);
    reg_rd(1, "n0_stat");

    for (int r = 0; r < 4; r++) begin
      n = $urandom_range(1, DEPTH);
      reg_wr(3, $urandom);
      for (int i = 0; i < DEPTH; i++) reg_wr(4, $urandom);
      reg_wr(2, 32'(n));
      reg_wr(0, {30'd0, 1'($urandom_range(0, 1)), 1'b1});
      wait_done("rnd");
      reg_rd(1, "rnd_stat");
      read_ybuf(n, "rnd_y");
    end

    // asynchronous reset in the middle of a feed
    reg_wr(2, 32'd32);
    reg_wr(0, 32'd3);
    repeat (5) @(posedge clk);
    #2;
    chk("pre_rst_vld", 32'(flt_vld), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_vld", 32'(flt_vld), 32'd0);
    chk("arst_int", 32'(irq), 32'd0);
    chk("arst_dat", bus.wb_dat_r, 32'd0);
    reset_model();
    vld_cnt = 0;
    #4;
    rst_n = 1'b1;
    repeat (LAT + 2) @(posedge clk);
    #1;
    chk("arst_no_feed", 32'(vld_cnt), 32'd0);
    reg_rd(1, "arst_stat");
    reg_rd(0, "arst_ctrl");
    reg_rd(2, "arst_len");
    reg_rd(3, "arst_waddr");
    reg_rd(5, "arst_raddr");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
